braille_hint_gen: RTL

- Encoder in the opposite direction to the switch-to-alphabet path: takes the 4-bit alphabet code of the current target letter and drives its 6-dot Braille cell onto six LEDs.
- Dots are revealed one position per tick, the full cell is held, then the display clears.
- Triggered by a debounced hint button pulse.
- Sits beside the random-letter load path; consumes the loaded letter and its display enable.

---
 rtl/braille_pkg.sv | 45 ++++
 rtl/braille_encode.sv | 32 +++
 rtl/braille_hint_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/braille_pkg.sv
// Shared Braille constants: widths, FSM state encoding and the A..P six-dot patterns.
// Also intended for reuse by the switch-to-alphabet decoder.
package braille_pkg;

    localparam int ALPHA_W = 4;
    localparam int DOT_W   = 6;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_HOLD   = 2'd2
    } hint_state_e;

    // Bit n is Braille dot n+1.
    localparam logic [DOT_W-1:0] PAT_A = 6'b000001;
    localparam logic [DOT_W-1:0] PAT_B = 6'b000011;
    localparam logic [DOT_W-1:0] PAT_C = 6'b001001;
    localparam logic [DOT_W-1:0] PAT_D = 6'b011001;
    localparam logic [DOT_W-1:0] PAT_E = 6'b010001;
    localparam logic [DOT_W-1:0] PAT_F = 6'b001011;
    localparam logic [DOT_W-1:0] PAT_G = 6'b011011;
    localparam logic [DOT_W-1:0] PAT_H = 6'b010011;
    localparam logic [DOT_W-1:0] PAT_I = 6'b001010;
    localparam logic [DOT_W-1:0] PAT_J = 6'b011010;
    localparam logic [DOT_W-1:0] PAT_K = 6'b000101;
    localparam logic [DOT_W-1:0] PAT_L = 6'b000111;
    localparam logic [DOT_W-1:0] PAT_M = 6'b001101;
    localparam logic [DOT_W-1:0] PAT_N = 6'b011101;
    localparam logic [DOT_W-1:0] PAT_O = 6'b010101;
    localparam logic [DOT_W-1:0] PAT_P = 6'b001111;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;

    // Mask with dots 0..k set, used to grow the revealed cell one dot at a time.
    function automatic logic [DOT_W-1:0] reveal_mask(input logic [IDX_W-1:0] k);
        logic [DOT_W-1:0] m;
        m = '0;
        for (int i = 0; i < DOT_W; i++) begin
            m[i] = (i <= int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/braille_encode.sv
// Combinational ROM: 4-bit alphabet code (0=A .. 15=P) to six-dot Braille pattern.
module braille_encode
    import braille_pkg::*;
(
    input  logic [ALPHA_W-1:0] code,
    output logic [DOT_W-1:0]   pat
);

    always_comb begin
        pat = '0;
        case (code)
            4'd0:    pat = PAT_A;
            4'd1:    pat = PAT_B;
            4'd2:    pat = PAT_C;
            4'd3:    pat = PAT_D;
            4'd4:    pat = PAT_E;
            4'd5:    pat = PAT_F;
            4'd6:    pat = PAT_G;
            4'd7:    pat = PAT_H;
            4'd8:    pat = PAT_I;
            4'd9:    pat = PAT_J;
            4'd10:   pat = PAT_K;
            4'd11:   pat = PAT_L;
            4'd12:   pat = PAT_M;
            4'd13:   pat = PAT_N;
            4'd14:   pat = PAT_O;
            4'd15:   pat = PAT_P;
            default: pat = '0;
        endcase
    end

endmodule

// File: rtl/braille_hint_gen.sv
// Hint generator: reveals the target letter's Braille cell dot by dot, holds it, then clears.
// Optional BRAILLE_BLINK_EN: the held cell blinks (pat / off) on each hold tick.
//
// state  | meaning
// IDLE   | LEDs dark, waiting for a hint request with a valid letter
// REVEAL | one more dot shown per tick until all six positions are covered
// HOLD   | full cell shown for HOLD_STEPS ticks, then Done pulses
module braille_hint_gen
    import braille_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int HOLD_STEPS = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Hint_Req,
    input  logic [ALPHA_W-1:0] Alpha_In,
    input  logic               Alpha_Valid,
    output logic [DOT_W-1:0]   Dot_Led,
    output logic               Busy,
    output logic               Done,
    output logic [3:0]         Hint_Count
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    hint_state_e         state_q, state_d;
    logic [DOT_W-1:0]    pat_q, pat_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DOT_W-1:0]    dot_led_q, dot_led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          hint_count_q, hint_count_d;

    logic [DOT_W-1:0]    enc_pat;
    logic                tick;

    braille_encode u_encode (
        .code (Alpha_In),
        .pat  (enc_pat)
    );

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        idx_d        = idx_q;
        tick_cnt_d   = tick_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        dot_led_d    = dot_led_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        hint_count_d = hint_count_q;

        case (state_q)
            ST_IDLE: begin
                dot_led_d  = '0;
                busy_d     = 1'b0;
                idx_d      = '0;
                tick_cnt_d = '0;
                hold_cnt_d = '0;
                if (Hint_Req && Alpha_Valid) begin
                    state_d   = ST_REVEAL;
                    pat_d     = enc_pat;
                    busy_d    = 1'b1;
                    dot_led_d = enc_pat & reveal_mask('0);
                    if (hint_count_q != 4'hF) begin
                        hint_count_d = hint_count_q + 4'd1;
                    end
                end
            end

            ST_REVEAL, ST_HOLD: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
                // A falling Alpha_Valid means a new letter is being loaded; drop the hint.
                if (!Alpha_Valid) begin
                    state_d    = ST_IDLE;
                    dot_led_d  = '0;
                    busy_d     = 1'b0;
                    idx_d      = '0;
                    tick_cnt_d = '0;
                    hold_cnt_d = '0;
                end else if (tick && state_q == ST_REVEAL) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d     = idx_q + 3'd1;
                        dot_led_d = pat_q & reveal_mask(idx_q + 3'd1);
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                        dot_led_d  = pat_q;
                    end
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_IDLE;
                        dot_led_d  = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        idx_d      = '0;
                        tick_cnt_d = '0;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`ifdef BRAILLE_BLINK_EN
                        dot_led_d  = hold_cnt_d[0] ? '0 : pat_q;
`else
                        dot_led_d  = pat_q;
`endif
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                dot_led_d  = '0;
                busy_d     = 1'b0;
                idx_d      = '0;
                tick_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            idx_q        <= '0;
            tick_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            dot_led_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hint_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            idx_q        <= idx_d;
            tick_cnt_q   <= tick_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            dot_led_q    <= dot_led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hint_count_q <= hint_count_d;
        end
    end

    assign Dot_Led    = dot_led_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Hint_Count = hint_count_q;

endmodule
